stream_fifo: RTL and testbench

STREAM_FIFO -- requirements
Module: stream_fifo

---
 rtl/stream_fifo.sv | 121 ++++++++++++
 tb/tb_stream_fifo.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// First-word-fall-through stream FIFO: block-RAM storage with a registered read
// port feeding one output register, ready/valid on both sides, flush and level flags.
module stream_fifo #(
    parameter int DATAW     = 32,
    parameter int DEPTH     = 1024,
    parameter int AFULL_TH  = DEPTH - 4,
    parameter int AEMPTY_TH = 4,
    localparam int ADDRW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [DATAW-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DATAW-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ADDRW:0]   count,
    output logic             almost_full,
    output logic             almost_empty
);

    localparam int CW = ADDRW + 1;

    logic [DATAW-1:0] mem_r [DEPTH];
    logic [DATAW-1:0] ram_q_r;
    logic [DATAW-1:0] out_data_r;
    logic [ADDRW-1:0] wr_ptr_r;
    logic [ADDRW-1:0] rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic [CW-1:0]    ram_words_s;
    logic             s1_valid_r;
    logic             out_valid_r;
    logic             afull_r;
    logic             aempty_r;
    logic             wr_s;
    logic             rd_s;
    logic             ram_rd_s;
    logic             out_load_s;
    logic             s1_valid_nxt_s;
    logic             out_valid_nxt_s;

    assign in_ready     = (count_r < CW'(DEPTH)) & ~flush;
    assign out_valid    = out_valid_r & ~flush;
    assign out_data     = out_data_r;
    assign count        = count_r;
    assign almost_full  = afull_r;
    assign almost_empty = aempty_r;

    // Handshakes, two-stage prefetch pipeline control and next occupancy.
    // ram_words_s counts words still in RAM, i.e. not yet in the read or output register.
    always_comb begin
        wr_s            = in_valid & in_ready;
        rd_s            = out_valid & out_ready;
        ram_words_s     = count_r - CW'(s1_valid_r) - CW'(out_valid_r);
        out_load_s      = s1_valid_r & (~out_valid_r | out_ready);
        ram_rd_s        = (ram_words_s != CW'(0)) & (~s1_valid_r | out_load_s);
        s1_valid_nxt_s  = ram_rd_s | (s1_valid_r & ~out_load_s);
        out_valid_nxt_s = out_load_s | (out_valid_r & ~out_ready);
        count_nxt_s     = count_r;
        case ({wr_s, rd_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // RAM write port; contents are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (wr_s & ~rst) begin
            mem_r[wr_ptr_r] <= in_data;
        end
    end

    // Registered RAM read port; holds its word while the output stage is stalled.
    always_ff @(posedge clk) begin
        if (ram_rd_s) begin
            ram_q_r <= mem_r[rd_ptr_r];
        end
    end

    // Pointers, pipeline valids, output register, occupancy and level flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r    <= ADDRW'(0);
            rd_ptr_r    <= ADDRW'(0);
            count_r     <= CW'(0);
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            out_data_r  <= DATAW'(0);
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
        end else if (flush) begin
            wr_ptr_r    <= ADDRW'(0);
            rd_ptr_r    <= ADDRW'(0);
            count_r     <= CW'(0);
            s1_valid_r  <= 1'b0;
            out_valid_r <= 1'b0;
            afull_r     <= 1'b0;
            aempty_r    <= 1'b1;
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + ADDRW'(1);
            end
            if (ram_rd_s) begin
                rd_ptr_r <= rd_ptr_r + ADDRW'(1);
            end
            if (out_load_s) begin
                out_data_r <= ram_q_r;
            end
            count_r     <= count_nxt_s;
            s1_valid_r  <= s1_valid_nxt_s;
            out_valid_r <= out_valid_nxt_s;
            afull_r     <= (count_nxt_s >= CW'(AFULL_TH));
            aempty_r    <= (count_nxt_s <= CW'(AEMPTY_TH));
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Bench for stream_fifo (DEPTH=16): directed scenarios plus random traffic, all
// checked each cycle against a queue model with a two-edge visibility rule.
module tb_stream_fifo;

    localparam int DATAW = 32;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 2;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [DATAW-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [DATAW-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       count;
    logic             almost_full;
    logic             almost_empty;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit known       = 1'b0;
    logic [31:0] dq[$];
    int          tq[$];

    stream_fifo #(.DATAW(DATAW), .DEPTH(DEPTH), .AFULL_TH(AF), .AEMPTY_TH(AE)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .almost_full(almost_full), .almost_empty(almost_empty)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check outputs mid-cycle against the model, advance the model at the edge.
    task automatic tick(input logic r, input logic fl, input logic iv, input logic [31:0] d, input logic ordy);
        logic ei;
        logic eo;
        rst = r; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        ei = (dq.size() < DEPTH) && !fl;
        eo = !fl && (dq.size() > 0) && ((cyc - tq[0]) >= 2);
        if (!r && known) begin
            chk("count", 32'(count), 32'(dq.size()));
            chk("count_bound", 32'(count <= 5'd16), 32'd1);
            chk("in_ready", 32'(in_ready), 32'(ei));
            chk("out_valid", 32'(out_valid), 32'(eo));
            chk("almost_full", 32'(almost_full), 32'(dq.size() >= AF));
            chk("almost_empty", 32'(almost_empty), 32'(dq.size() <= AE));
            if (eo) chk("out_data", out_data, dq[0]);
        end
        @(posedge clk);
        cyc++;
        if (r || fl) begin
            dq.delete();
            tq.delete();
        end else begin
            if (eo && ordy) begin
                void'(dq.pop_front());
                void'(tq.pop_front());
            end
            if (ei && iv) begin
                dq.push_back(d);
                tq.push_back(cyc);
            end
        end
        if (r) known = 1'b1;
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 32'd0; out_ready = 1'b0;
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_aempty", 32'(almost_empty), 32'd1);
        chk("rst_afull", 32'(almost_full), 32'd0);

        // single word latency and hold while stalled
        tick(1'b0, 1'b0, 1'b1, 32'hA5, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // fill to full, 17th offer refused
        for (int i = 0; i < 17; i++) tick(1'b0, 1'b0, 1'b1, 32'(i), 1'b0);
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // 40-word continuous stream
        for (int i = 0; i < 40; i++) tick(1'b0, 1'b0, 1'b1, 32'(i), 1'b1);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // steady occupancy of 3, then drop to 2
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 32'(100 + i), 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0, 1'b1, 32'(200 + i), 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
        tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // flush with a pending offer, then a fresh word emerges first
        for (int i = 0; i < 8; i++) tick(1'b0, 1'b0, 1'b1, 32'(300 + i), 1'b0);
        tick(1'b0, 1'b1, 1'b1, 32'hDEAD, 1'b1);
        tick(1'b0, 1'b0, 1'b1, 32'h77, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // reset mid-stream wins over flush and transfers
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b1, 32'(400 + i), 1'b0);
        tick(1'b1, 1'b1, 1'b1, 32'hBEEF, 1'b1);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        // random traffic with rare flushes
        for (int i = 0; i < 1000; i++) begin
            tick(1'b0, ($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20; i++) tick(1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
